// File: rtl/npc_bus_arbiter.sv
// Two-master (IFU = m0, LSU = m1) to one-slave bus arbiter, one transaction in flight at a time.
// Define NPC_BUS_ARB_RR_EN for round-robin tie breaking; the default is fixed priority, LSU first.
module npc_bus_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  // master 0 (IFU)
  input  logic            m0_req_valid,
  output logic            m0_req_ready,
  input  logic [AW-1:0]   m0_req_addr,
  input  logic            m0_req_wen,
  input  logic [DW-1:0]   m0_req_wdata,
  input  logic [DW/8-1:0] m0_req_wmask,
  output logic            m0_rsp_valid,
  input  logic            m0_rsp_ready,
  output logic [DW-1:0]   m0_rsp_rdata,
  output logic            m0_rsp_err,
  // master 1 (LSU)
  input  logic            m1_req_valid,
  output logic            m1_req_ready,
  input  logic [AW-1:0]   m1_req_addr,
  input  logic            m1_req_wen,
  input  logic [DW-1:0]   m1_req_wdata,
  input  logic [DW/8-1:0] m1_req_wmask,
  output logic            m1_rsp_valid,
  input  logic            m1_rsp_ready,
  output logic [DW-1:0]   m1_rsp_rdata,
  output logic            m1_rsp_err,
  // slave
  output logic            s_req_valid,
  input  logic            s_req_ready,
  output logic [AW-1:0]   s_req_addr,
  output logic            s_req_wen,
  output logic [DW-1:0]   s_req_wdata,
  output logic [DW/8-1:0] s_req_wmask,
  input  logic            s_rsp_valid,
  output logic            s_rsp_ready,
  input  logic [DW-1:0]   s_rsp_rdata,
  input  logic            s_rsp_err,
  // status
  output logic            arb_owner,
  output logic            arb_busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RSP  = 2'd2;

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_grant_q, last_grant_d;
  logic       grant;
  logic       in_req, in_rsp;
  logic       own_req_valid, own_rsp_ready;

  assign in_req = (state_q == REQ);
  assign in_rsp = (state_q == RSP);

  // Only consulted when at least one master is requesting.
  always_comb begin
`ifdef NPC_BUS_ARB_RR_EN
    if (m0_req_valid && m1_req_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = m1_req_valid;
    end
`else
    grant = m1_req_valid;
`endif
  end

  assign own_req_valid = owner_q ? m1_req_valid : m0_req_valid;
  assign own_rsp_ready = owner_q ? m1_rsp_ready : m0_rsp_ready;

  // Request path: fields follow the owner; valid/ready only exist in REQ.
  assign s_req_valid  = in_req & own_req_valid;
  assign s_req_addr   = owner_q ? m1_req_addr  : m0_req_addr;
  assign s_req_wen    = owner_q ? m1_req_wen   : m0_req_wen;
  assign s_req_wdata  = owner_q ? m1_req_wdata : m0_req_wdata;
  assign s_req_wmask  = owner_q ? m1_req_wmask : m0_req_wmask;
  assign m0_req_ready = in_req & ~owner_q & s_req_ready;
  assign m1_req_ready = in_req &  owner_q & s_req_ready;

  // Response path: stray slave responses outside RSP never reach a master.
  assign s_rsp_ready  = in_rsp & own_rsp_ready;
  assign m0_rsp_valid = in_rsp & ~owner_q & s_rsp_valid;
  assign m1_rsp_valid = in_rsp &  owner_q & s_rsp_valid;
  assign m0_rsp_rdata = (in_rsp & ~owner_q) ? s_rsp_rdata : '0;
  assign m1_rsp_rdata = (in_rsp &  owner_q) ? s_rsp_rdata : '0;
  assign m0_rsp_err   = in_rsp & ~owner_q & s_rsp_err;
  assign m1_rsp_err   = in_rsp &  owner_q & s_rsp_err;

  assign arb_owner = owner_q;
  assign arb_busy  = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (m0_req_valid || m1_req_valid) begin
          owner_d = grant;
          state_d = REQ;
        end
      end
      REQ: begin
        if (own_req_valid && s_req_ready) state_d = RSP;
      end
      RSP: begin
        if (s_rsp_valid && own_rsp_ready) begin
          state_d      = IDLE;
          last_grant_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule
